// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared scalar types used across the pipeline
package common;

  typedef logic [4:0]  u5;
  typedef u5           creg_addr_t;
  typedef logic [63:0] word_t;

endpackage

// File: rtl/pipes_pkg.sv
// rtl/pipes_pkg.sv - pipeline-stage payload types and scoreboard sizing
package pipes;

  import common::*;

  // Producer descriptor for one pipeline stage (EX, MEM or WB).
  //   valid : stage holds an instruction that writes dst
  //   ready : data is final and may be forwarded
  typedef struct packed {
    logic       valid;
    logic       ready;
    creg_addr_t dst;
    word_t      data;
  } fwd_t;

  localparam int SB_CNT_W = 2;

endpackage

// File: rtl/scoreboard_fwd_select.sv
// rtl/scoreboard_fwd_select.sv - resolve one source operand from forward paths or register file
//
// Ports:
//   ra      in  : source register index
//   rf      in  : register-file read data for ra
//   ex_fwd  in  : EX-stage producer
//   mem_fwd in  : MEM-stage producer
//   wb_fwd  in  : WB-stage producer
//   pend_nz in  : pending-write counter for ra is non-zero
//   value   out : resolved operand value
//   bubble  out : operand not yet available
module fwd_select
  import common::*;
  import pipes::*;
(
  input  creg_addr_t ra,
  input  word_t      rf,
  input  fwd_t       ex_fwd,
  input  fwd_t       mem_fwd,
  input  fwd_t       wb_fwd,
  input  logic       pend_nz,
  output word_t      value,
  output logic       bubble
);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  assign ex_hit  = ex_fwd.valid  && (ex_fwd.dst  == ra);
  assign mem_hit = mem_fwd.valid && (mem_fwd.dst == ra);
  assign wb_hit  = wb_fwd.valid  && (wb_fwd.dst  == ra);

  // The youngest producer wins; a not-ready match stalls even if an older
  // stage holds a ready value, since the older value is stale.
  always_comb begin
    value  = rf;
    bubble = 1'b0;
    if (ra == '0) begin
      value = '0;
    end else if (ex_hit) begin
      if (ex_fwd.ready) value = ex_fwd.data;
      else              bubble = 1'b1;
    end else if (mem_hit) begin
      if (mem_fwd.ready) value = mem_fwd.data;
      else               bubble = 1'b1;
    end else if (wb_hit) begin
      if (wb_fwd.ready) value = wb_fwd.data;
      else              bubble = 1'b1;
    end else if (pend_nz) begin
      // Producer is outside the forward stages (e.g. a multi-cycle unit).
      bubble = 1'b1;
    end
  end

endmodule

// File: rtl/scoreboard.sv
// rtl/scoreboard.sv - per-register pending-write tracker with operand forwarding
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   ra1, ra2            : decode source register indices
//   rf1, rf2            : register-file read data for ra1/ra2
//   issue_valid         : decode instruction advances into EX this cycle
//   issue_wen, issue_rd : issuing instruction writes issue_rd
//   ex_fwd/mem_fwd/wb_fwd : in-flight producers
//   wb_commit           : WB writes wb_fwd.dst to the register file
//   scra, scrb          : resolved operands
//   bubble1, bubble2    : operand not yet available
//   sb_err              : sticky counter overflow/underflow
module scoreboard
  import common::*;
  import pipes::*;
#(
  parameter int CNT_W = SB_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  creg_addr_t ra1,
  input  creg_addr_t ra2,
  input  word_t      rf1,
  input  word_t      rf2,
  input  logic       issue_valid,
  input  logic       issue_wen,
  input  creg_addr_t issue_rd,
  input  fwd_t       ex_fwd,
  input  fwd_t       mem_fwd,
  input  fwd_t       wb_fwd,
  input  logic       wb_commit,
  output word_t      scra,
  output word_t      scrb,
  output logic       bubble1,
  output logic       bubble2,
  output logic       sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // x0 is hard-wired zero, so it has no counter.
  logic [CNT_W-1:0] pend [31:1];

  logic pnz1;
  logic pnz2;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 1; r < 32; r++) pend[r] <= '0;
      sb_err <= 1'b0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        logic inc;
        logic dec;
        inc = issue_valid && issue_wen && (issue_rd == 5'(r));
        dec = wb_commit && (wb_fwd.dst == 5'(r));
        // inc and dec together cancel and leave the counter untouched.
        if (inc && !dec) begin
          if (pend[r] == CNT_MAX) sb_err <= 1'b1;
          else                    pend[r] <= pend[r] + 1'b1;
        end else if (dec && !inc) begin
          if (pend[r] == '0) sb_err <= 1'b1;
          else               pend[r] <= pend[r] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    pnz1 = 1'b0;
    pnz2 = 1'b0;
    for (int r = 1; r < 32; r++) begin
      if (ra1 == 5'(r)) pnz1 = |pend[r];
      if (ra2 == 5'(r)) pnz2 = |pend[r];
    end
  end

  fwd_select u_sel_a (
    .ra      (ra1),
    .rf      (rf1),
    .ex_fwd  (ex_fwd),
    .mem_fwd (mem_fwd),
    .wb_fwd  (wb_fwd),
    .pend_nz (pnz1),
    .value   (scra),
    .bubble  (bubble1)
  );

  fwd_select u_sel_b (
    .ra      (ra2),
    .rf      (rf2),
    .ex_fwd  (ex_fwd),
    .mem_fwd (mem_fwd),
    .wb_fwd  (wb_fwd),
    .pend_nz (pnz2),
    .value   (scrb),
    .bubble  (bubble2)
  );

endmodule

// File: tb/tb_scoreboard.sv
// tb/tb_scoreboard.sv - self-checking bench for scoreboard
module tb_scoreboard;

  import common::*;
  import pipes::*;

  logic       clk = 1'b0;
  logic       reset;
  creg_addr_t ra1, ra2;
  word_t      rf1, rf2;
  logic       issue_valid, issue_wen;
  creg_addr_t issue_rd;
  fwd_t       ex_fwd, mem_fwd, wb_fwd;
  logic       wb_commit;
  word_t      scra, scrb;
  logic       bubble1, bubble2, sb_err;

  always #5 clk = ~clk;

  scoreboard dut (
    .clk         (clk),
    .reset       (reset),
    .ra1         (ra1),
    .ra2         (ra2),
    .rf1         (rf1),
    .rf2         (rf2),
    .issue_valid (issue_valid),
    .issue_wen   (issue_wen),
    .issue_rd    (issue_rd),
    .ex_fwd      (ex_fwd),
    .mem_fwd     (mem_fwd),
    .wb_fwd      (wb_fwd),
    .wb_commit   (wb_commit),
    .scra        (scra),
    .scrb        (scrb),
    .bubble1     (bubble1),
    .bubble2     (bubble2),
    .sb_err      (sb_err)
  );

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;

  task automatic expect_val(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    q.push_back(e);
  endtask

  task automatic check(input logic [63:0] obs);
    exp_t e;
    total++;
    if (q.size() == 0) begin
      $error("FAIL queue_empty observed=%h expected=<none>", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.val) passed++;
      else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  function automatic fwd_t mk(input logic v, input logic r, input logic [4:0] d,
                              input logic [63:0] x);
    fwd_t f;
    f.valid = v;
    f.ready = r;
    f.dst   = d;
    f.data  = x;
    return f;
  endfunction

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    ex_fwd    = '0;
    mem_fwd   = '0;
    wb_fwd    = '0;
    wb_commit = 1'b0;
    issue_valid = 1'b0;
    issue_wen   = 1'b0;
    issue_rd    = '0;
  endtask

  initial begin
    logic any_pend;
    reset = 1'b1;
    ra1 = 5'd5; ra2 = 5'd0;
    rf1 = 64'h11; rf2 = 64'h22;
    clear_fwd();

    // Reset
    tick();
    reset = 1'b0;
    #1;
    any_pend = 1'b0;
    for (int r = 1; r < 32; r++) any_pend |= (dut.pend[r] != '0);
    expect_val("rst_pend_any", 64'd0);  check(64'(any_pend));
    expect_val("rst_sb_err",   64'd0);  check(64'(sb_err));
    expect_val("rst_scra",     64'h11); check(scra);
    expect_val("rst_bubble1",  64'd0);  check(64'(bubble1));
    expect_val("rst_scrb_x0",  64'd0);  check(scrb);

    // Forward priority
    issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = 5'd5;
    tick();
    clear_fwd();
    ex_fwd  = mk(1'b1, 1'b1, 5'd5, 64'hAA);
    mem_fwd = mk(1'b1, 1'b1, 5'd5, 64'hBB);
    #1;
    expect_val("prio_ex_scra",  64'hAA); check(scra);
    expect_val("prio_ex_bub",   64'd0);  check(64'(bubble1));
    ex_fwd = '0;
    #1;
    expect_val("prio_mem_scra", 64'hBB); check(scra);
    mem_fwd   = '0;
    wb_fwd    = mk(1'b1, 1'b1, 5'd5, 64'hCC);
    wb_commit = 1'b1;
    #1;
    expect_val("prio_wb_scra",  64'hCC); check(scra);
    tick();
    clear_fwd();
    #1;
    expect_val("x5_pend_clear", 64'd0);  check(64'(dut.pend[5]));
    expect_val("x5_rf_scra",    64'h11); check(scra);

    // Load-use
    ra2 = 5'd7; rf2 = 64'h77;
    ex_fwd = mk(1'b1, 1'b0, 5'd7, 64'h0);
    #1;
    expect_val("lu_bubble2",   64'd1);  check(64'(bubble2));
    expect_val("lu_scrb_rf",   64'h77); check(scrb);
    tick();
    ex_fwd  = '0;
    mem_fwd = mk(1'b1, 1'b1, 5'd7, 64'h42);
    #1;
    expect_val("lu_scrb_fwd",  64'h42); check(scrb);
    expect_val("lu_bubble2_0", 64'd0);  check(64'(bubble2));
    clear_fwd();

    // Multi-cycle producer
    ra1 = 5'd9; rf1 = 64'h5;
    issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = 5'd9;
    tick();
    clear_fwd();
    for (int i = 0; i < 10; i++) begin
      #1;
      expect_val($sformatf("mc_bubble_%0d", i), 64'd1);
      check(64'(bubble1));
      tick();
    end
    wb_fwd    = mk(1'b1, 1'b1, 5'd9, 64'h99);
    wb_commit = 1'b1;
    #1;
    expect_val("mc_wb_scra",   64'h99); check(scra);
    expect_val("mc_wb_bub",    64'd0);  check(64'(bubble1));
    tick();
    clear_fwd();
    #1;
    expect_val("mc_pend9",     64'd0);  check(64'(dut.pend[9]));
    expect_val("mc_after_bub", 64'd0);  check(64'(bubble1));

    // Simultaneous issue and commit
    issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = 5'd3;
    tick();
    wb_fwd    = mk(1'b1, 1'b1, 5'd3, 64'h33);
    wb_commit = 1'b1;
    tick();
    clear_fwd();
    #1;
    expect_val("sim_pend3",    64'd1);  check(64'(dut.pend[3]));
    expect_val("sim_err",      64'd0);  check(64'(sb_err));
    wb_fwd    = mk(1'b1, 1'b1, 5'd3, 64'h34);
    wb_commit = 1'b1;
    tick();
    clear_fwd();
    #1;
    expect_val("sim_pend3_0",  64'd0);  check(64'(dut.pend[3]));
    expect_val("sim_err_0",    64'd0);  check(64'(sb_err));
    ra1 = 5'd0; rf1 = 64'h123;
    ex_fwd = mk(1'b1, 1'b1, 5'd0, 64'hFF);
    #1;
    expect_val("x0_scra",      64'd0);  check(scra);
    expect_val("x0_bubble1",   64'd0);  check(64'(bubble1));
    clear_fwd();

    // Underflow
    wb_fwd    = mk(1'b1, 1'b1, 5'd4, 64'h44);
    wb_commit = 1'b1;
    tick();
    clear_fwd();
    #1;
    expect_val("uf_err",       64'd1);  check(64'(sb_err));
    expect_val("uf_pend4",     64'd0);  check(64'(dut.pend[4]));
    tick(); tick(); tick();
    expect_val("uf_err_stick", 64'd1);  check(64'(sb_err));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    expect_val("uf_err_rst",   64'd0);  check(64'(sb_err));

    // Overflow
    ra1 = 5'd6; rf1 = 64'h66;
    issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = 5'd6;
    tick(); tick(); tick();
    #1;
    expect_val("of_pend6_3",   64'd3);  check(64'(dut.pend[6]));
    expect_val("of_err_0",     64'd0);  check(64'(sb_err));
    tick();
    clear_fwd();
    #1;
    expect_val("of_pend6_sat", 64'd3);  check(64'(dut.pend[6]));
    expect_val("of_err_1",     64'd1);  check(64'(sb_err));
    expect_val("of_bubble1",   64'd1);  check(64'(bubble1));

    // Issue without write-enable must not count
    issue_valid = 1'b1; issue_wen = 1'b0; issue_rd = 5'd8;
    tick();
    clear_fwd();
    #1;
    expect_val("nowen_pend8",  64'd0);  check(64'(dut.pend[8]));

    if (q.size() != 0) begin
      total++;
      $error("FAIL queue_leftover observed=%0d expected=0", q.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
